// File: rtl/k10_peri_axil_master_if.sv
// K10 peripheral AXI4-Lite bus bundle: the five AXI4-Lite channels between
// the peripheral master and the address decoder.
interface k10_peri_axil_master_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/k10_peri_axil_master.sv
// K10 peripheral AXI4-Lite master: turns the core's single-outstanding
// req/gnt data-port request into one AXI4-Lite transaction, reports the
// response as a one-cycle o_rvalid pulse, and times out stuck slaves while
// still completing the AXI handshakes of the abandoned transaction.
module k10_peri_axil_master #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    output logic        o_gnt,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    input  logic        i_priv,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    k10_peri_axil_master_if.master m_axi
);

    // Counter just wide enough to hold TIMEOUT_CYCLES itself.
    localparam int CW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 32'sd1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam bit            TO_EN    = (TIMEOUT_CYCLES != 32'd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic [2:0]      r_prot;
    logic            r_is_write;
    logic            r_aw_done;
    logic            r_w_done;
    logic            r_ar_done;
    logic [CW-1:0]   r_cnt;
    logic            r_rvalid;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_grant;
    logic            w_busy;
    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_ar_hs;
    logic            w_b_hs;
    logic            w_r_hs;
    logic            w_resp_hs;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_timeout;

    assign w_grant   = (r_state == ST_IDLE) && i_req;
    assign w_busy    = (r_state == ST_WRITE) || (r_state == ST_READ);
    assign w_aw_hs   = m_axi.awvalid && m_axi.awready;
    assign w_w_hs    = m_axi.wvalid  && m_axi.wready;
    assign w_ar_hs   = m_axi.arvalid && m_axi.arready;
    assign w_b_hs    = m_axi.bvalid  && m_axi.bready;
    assign w_r_hs    = m_axi.rvalid  && m_axi.rready;
    assign w_resp_hs = r_is_write ? w_b_hs : w_r_hs;
    assign w_cnt_inc = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    // A response arriving in the expiry cycle wins over the timeout.
    assign w_timeout = TO_EN && w_busy && !w_resp_hs && (w_cnt_inc == TO_LIMIT);

    // Address/data/prot come straight from the request registers so they stay
    // stable for the whole transaction, including while draining.
    assign m_axi.awaddr = r_addr;
    assign m_axi.awprot = r_prot;
    assign m_axi.wdata  = r_wdata;
    assign m_axi.wstrb  = r_be;
    assign m_axi.araddr = r_addr;
    assign m_axi.arprot = r_prot;

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_err    = r_err;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: complete on the response handshake, divert to DRAIN on timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_state_nxt = i_we ? ST_WRITE : ST_READ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (w_b_hs) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_READ: begin
                if (w_r_hs) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (w_resp_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: valids drop only after their own handshake; DRAIN keeps the same channel behaviour.
    always_comb begin
        o_gnt         = 1'b0;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_gnt = i_req;
            end
            ST_WRITE: begin
                m_axi.awvalid = !r_aw_done;
                m_axi.wvalid  = !r_w_done;
                m_axi.bready  = r_aw_done && r_w_done;
            end
            ST_READ: begin
                m_axi.arvalid = !r_ar_done;
                m_axi.rready  = r_ar_done;
            end
            ST_DRAIN: begin
                if (r_is_write) begin
                    m_axi.awvalid = !r_aw_done;
                    m_axi.wvalid  = !r_w_done;
                    m_axi.bready  = r_aw_done && r_w_done;
                end else begin
                    m_axi.arvalid = !r_ar_done;
                    m_axi.rready  = r_ar_done;
                end
            end
            default: begin
                o_gnt = 1'b0;
            end
        endcase
    end

    // Request capture on grant, per-channel done flags and the timeout counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
            r_be       <= 4'h0;
            r_prot     <= 3'b000;
            r_is_write <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_ar_done  <= 1'b0;
            r_cnt      <= {CW{1'b0}};
        end else if (w_grant) begin
            r_addr     <= i_addr;
            r_wdata    <= i_wdata;
            r_be       <= i_be;
            r_prot     <= {1'b0, 1'b0, i_priv};
            r_is_write <= i_we;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_ar_done  <= 1'b0;
            r_cnt      <= {CW{1'b0}};
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (w_ar_hs) begin
                r_ar_done <= 1'b1;
            end
            if (w_busy) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Core response: one-cycle pulse after a B/R handshake or on timeout; drained responses are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0000_0000;
        end else if ((r_state == ST_WRITE) && w_b_hs) begin
            r_rvalid <= 1'b1;
            r_err    <= (m_axi.bresp != 2'b00);
            r_rdata  <= 32'h0000_0000;
        end else if ((r_state == ST_READ) && w_r_hs) begin
            r_rvalid <= 1'b1;
            r_err    <= (m_axi.rresp != 2'b00);
            r_rdata  <= m_axi.rdata;
        end else if (w_timeout) begin
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_rdata  <= 32'h0000_0000;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_k10_peri_axil_master.sv
// Testbench for k10_peri_axil_master: cycle-scripted AXI slave responses,
// a response scoreboard and an AXI valid-stability monitor.
module tb_k10_peri_axil_master;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req;
    logic        o_gnt;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_be;
    logic        i_priv;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;

    k10_peri_axil_master_if axi ();

    k10_peri_axil_master #(.TIMEOUT_CYCLES(32'd8)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req),
        .o_gnt    (o_gnt),
        .i_we     (i_we),
        .i_addr   (i_addr),
        .i_wdata  (i_wdata),
        .i_be     (i_be),
        .i_priv   (i_priv),
        .o_rvalid (o_rvalid),
        .o_rdata  (o_rdata),
        .o_err    (o_err),
        .m_axi    (axi)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Scoreboard: every o_rvalid pulse must match the oldest pending expectation.
    always @(negedge i_clk) begin
        if (i_rst_n && o_rvalid) begin
            n_pulses++;
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_rvalid got rdata=%h err=%0b, no response expected", o_rdata, o_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (o_rdata !== e.rdata || o_err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_resp got rdata=%h err=%0b exp rdata=%h err=%0b", o_rdata, o_err, e.rdata, e.err);
                end
            end
        end
    end

    // AXI stability: a pending valid must stay up with its payload unchanged.
    logic        p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    logic [2:0]  p_awprot, p_arprot;
    always begin
        @(negedge i_clk);
        #2;
        if (!i_rst_n) begin
            p_aw = 1'b0;
            p_w  = 1'b0;
            p_ar = 1'b0;
        end else begin
            if (p_aw) begin
                n_tests++;
                if (axi.awvalid !== 1'b1 || axi.awaddr !== p_awaddr || axi.awprot !== p_awprot) begin
                    n_fail++;
                    $display("FAIL axi_aw_stable got v=%0b a=%h exp v=1 a=%h", axi.awvalid, axi.awaddr, p_awaddr);
                end
            end
            if (p_w) begin
                n_tests++;
                if (axi.wvalid !== 1'b1 || axi.wdata !== p_wdata || axi.wstrb !== p_wstrb) begin
                    n_fail++;
                    $display("FAIL axi_w_stable got v=%0b d=%h exp v=1 d=%h", axi.wvalid, axi.wdata, p_wdata);
                end
            end
            if (p_ar) begin
                n_tests++;
                if (axi.arvalid !== 1'b1 || axi.araddr !== p_araddr || axi.arprot !== p_arprot) begin
                    n_fail++;
                    $display("FAIL axi_ar_stable got v=%0b a=%h exp v=1 a=%h", axi.arvalid, axi.araddr, p_araddr);
                end
            end
            p_aw = axi.awvalid && !axi.awready;
            p_w  = axi.wvalid && !axi.wready;
            p_ar = axi.arvalid && !axi.arready;
            p_awaddr = axi.awaddr;
            p_awprot = axi.awprot;
            p_wdata  = axi.wdata;
            p_wstrb  = axi.wstrb;
            p_araddr = axi.araddr;
            p_arprot = axi.arprot;
        end
    end

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_req = 1'b0; i_we = 1'b0; i_addr = 32'h0; i_wdata = 32'h0; i_be = 4'h0; i_priv = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00;
        @(negedge i_clk);
        @(negedge i_clk); #1;
        n_tests++;
        if ({o_gnt, o_rvalid, o_err, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 00000000",
                     {o_gnt, o_rvalid, o_err, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
        end
        n_tests++;
        if (o_rdata !== 32'h0 || axi.awaddr !== 32'h0 || axi.wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data got rdata=%h awaddr=%h wdata=%h exp 0", o_rdata, axi.awaddr, axi.wdata);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1; #1;
        n_tests++;
        if (o_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_idle got %0b exp 0", o_gnt); end
    endtask

    task automatic test_write_aw_first();
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h4000_1000; i_wdata = 32'hDEAD_BEEF; i_be = 4'hF; i_priv = 1'b1; #1;
        n_tests++;
        if (o_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt got %0b exp 1", o_gnt); end
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
        @(negedge i_clk);                                   // cycle 1
        i_req = 1'b0; i_addr = 32'h0; i_wdata = 32'h0; axi.awready = 1'b1; #1;
        n_tests++;
        if (axi.awvalid !== 1'b1 || axi.awaddr !== 32'h4000_1000 || axi.awprot !== 3'b001) begin
            n_fail++;
            $display("FAIL wr_aw_c1 got v=%0b a=%h p=%b exp v=1 a=40001000 p=001", axi.awvalid, axi.awaddr, axi.awprot);
        end
        @(negedge i_clk);                                   // cycle 2
        axi.awready = 1'b0; #1;
        n_tests++;
        if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b1 || axi.bready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_c2 got aw=%0b w=%0b b=%0b exp 0 1 0", axi.awvalid, axi.wvalid, axi.bready);
        end
        @(negedge i_clk);                                   // cycle 3
        axi.wready = 1'b1; #1;
        n_tests++;
        if (axi.wvalid !== 1'b1 || axi.wdata !== 32'hDEAD_BEEF || axi.wstrb !== 4'hF) begin
            n_fail++;
            $display("FAIL wr_w_c3 got v=%0b d=%h s=%h exp v=1 d=deadbeef s=f", axi.wvalid, axi.wdata, axi.wstrb);
        end
        @(negedge i_clk);                                   // cycle 4
        axi.wready = 1'b0; #1;
        n_tests++;
        if (axi.wvalid !== 1'b0 || axi.bready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_c4 got w=%0b b=%0b exp 0 1", axi.wvalid, axi.bready);
        end
        @(negedge i_clk);                                   // cycle 5
        axi.bvalid = 1'b1; axi.bresp = 2'b00; #1;
        n_tests++;
        if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid_c5 got %0b exp 0", o_rvalid); end
        @(negedge i_clk);                                   // cycle 6
        axi.bvalid = 1'b0; #1;
        n_tests++;
        if (o_rvalid !== 1'b1 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rvalid_c6 got v=%0b e=%0b exp v=1 e=0", o_rvalid, o_err);
        end
        @(negedge i_clk); #1;
        n_tests++;
        if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_len got %0b exp 0", o_rvalid); end
    endtask

    task automatic test_read();
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h4000_0008; i_priv = 1'b0; #1;
        n_tests++;
        if (o_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt got %0b exp 1", o_gnt); end
        sb_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        @(negedge i_clk);
        i_req = 1'b0; axi.arready = 1'b1; #1;
        n_tests++;
        if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h4000_0008 || axi.arprot !== 3'b000) begin
            n_fail++;
            $display("FAIL rd_ar got v=%0b a=%h p=%b exp v=1 a=40000008 p=000", axi.arvalid, axi.araddr, axi.arprot);
        end
        @(negedge i_clk);
        axi.arready = 1'b0; #1;
        n_tests++;
        if (axi.arvalid !== 1'b0 || axi.rready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_rready got ar=%0b r=%0b exp 0 1", axi.arvalid, axi.rready);
        end
        @(negedge i_clk);
        axi.rvalid = 1'b1; axi.rdata = 32'h1234_5678; axi.rresp = 2'b00; #1;
        @(negedge i_clk);
        axi.rvalid = 1'b0; axi.rdata = 32'h0; #1;
        n_tests++;
        if (o_rvalid !== 1'b1 || o_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL rd_resp got v=%0b d=%h exp v=1 d=12345678", o_rvalid, o_rdata);
        end
        @(negedge i_clk); #1;
        n_tests++;
        if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_len got %0b exp 0", o_rvalid); end
    endtask

    task automatic test_errors();
        // write with AW and W accepted together, SLVERR response
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h4000_0100; i_wdata = 32'h0000_0011; i_be = 4'h3; #1;
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        @(negedge i_clk);
        i_req = 1'b0; axi.awready = 1'b1; axi.wready = 1'b1; #1;
        n_tests++;
        if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || axi.wstrb !== 4'h3) begin
            n_fail++;
            $display("FAIL err_wr_same got aw=%0b w=%0b s=%h exp 1 1 3", axi.awvalid, axi.wvalid, axi.wstrb);
        end
        @(negedge i_clk);
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b10; #1;
        n_tests++;
        if (axi.bready !== 1'b1) begin n_fail++; $display("FAIL err_wr_bready got %0b exp 1", axi.bready); end
        @(negedge i_clk);
        axi.bvalid = 1'b0; axi.bresp = 2'b00; #1;
        n_tests++;
        if (o_rvalid !== 1'b1 || o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_slverr got v=%0b e=%0b exp 1 1", o_rvalid, o_err);
        end
        // read with DECERR response
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h4000_0200; #1;
        sb_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b1});
        @(negedge i_clk);
        i_req = 1'b0; axi.arready = 1'b1;
        @(negedge i_clk);
        axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_F00D; axi.rresp = 2'b11;
        @(negedge i_clk);
        axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00; #1;
        n_tests++;
        if (o_rvalid !== 1'b1 || o_err !== 1'b1 || o_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL err_decerr got v=%0b e=%0b d=%h exp 1 1 cafef00d", o_rvalid, o_err, o_rdata);
        end
    endtask

    task automatic test_timeout();
        int pulses0;
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h4000_0010; #1;
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        pulses0 = n_pulses;
        @(negedge i_clk);                                   // cycle 1
        i_req = 1'b0; axi.arready = 1'b1;
        for (int c = 2; c <= 8; c++) begin
            @(negedge i_clk);
            axi.arready = 1'b0; #1;
            n_tests++;
            if (o_rvalid !== 1'b0) begin n_fail++; $display("FAIL to_early c%0d got %0b exp 0", c, o_rvalid); end
        end
        @(negedge i_clk);                                   // cycle 9
        i_req = 1'b1; #1;
        n_tests++;
        if (o_rvalid !== 1'b1 || o_err !== 1'b1 || o_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL to_c9 got v=%0b e=%0b g=%0b exp 1 1 0", o_rvalid, o_err, o_gnt);
        end
        for (int c = 10; c <= 19; c++) begin
            @(negedge i_clk); #1;
            n_tests++;
            if (o_gnt !== 1'b0 || axi.rready !== 1'b1 || o_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL to_drain c%0d got g=%0b rr=%0b v=%0b exp 0 1 0", c, o_gnt, axi.rready, o_rvalid);
            end
        end
        @(negedge i_clk);                                   // cycle 20
        axi.rvalid = 1'b1; axi.rdata = 32'hBAD0_BAD0; #1;
        n_tests++;
        if (o_gnt !== 1'b0 || axi.rready !== 1'b1) begin
            n_fail++;
            $display("FAIL to_late_r got g=%0b rr=%0b exp 0 1", o_gnt, axi.rready);
        end
        @(negedge i_clk);                                   // cycle 21
        i_req = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; #1;
        n_tests++;
        if (o_rvalid !== 1'b0 || axi.rready !== 1'b0) begin
            n_fail++;
            $display("FAIL to_discard got v=%0b rr=%0b exp 0 0", o_rvalid, axi.rready);
        end
        @(negedge i_clk); #1;
        n_tests++;
        if (n_pulses !== pulses0 + 1) begin
            n_fail++;
            $display("FAIL to_pulse_count got %0d exp %0d", n_pulses - pulses0, 1);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h4000_0020; i_priv = 1'b1; #1;
        n_tests++;
        if (o_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt1 got %0b exp 1", o_gnt); end
        sb_q.push_back('{rdata: 32'h0A0A_0A0A, err: 1'b0});
        @(negedge i_clk);
        i_addr = 32'h4000_0024; axi.arready = 1'b1; #1;
        n_tests++;
        if (o_gnt !== 1'b0 || axi.araddr !== 32'h4000_0020 || axi.arprot !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_busy got g=%0b a=%h p=%b exp 0 40000020 001", o_gnt, axi.araddr, axi.arprot);
        end
        @(negedge i_clk);
        axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'h0A0A_0A0A;
        @(negedge i_clk);
        axi.rvalid = 1'b0; #1;
        n_tests++;
        if (o_rvalid !== 1'b1 || o_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_overlap got v=%0b g=%0b exp 1 1", o_rvalid, o_gnt);
        end
        sb_q.push_back('{rdata: 32'hB0B0_B0B0, err: 1'b0});
        @(negedge i_clk);
        i_req = 1'b0; axi.arready = 1'b1; #1;
        n_tests++;
        if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h4000_0024) begin
            n_fail++;
            $display("FAIL b2b_ar2 got v=%0b a=%h exp 1 40000024", axi.arvalid, axi.araddr);
        end
        @(negedge i_clk);
        axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'hB0B0_B0B0;
        @(negedge i_clk);
        axi.rvalid = 1'b0; axi.rdata = 32'h0; #1;
        n_tests++;
        if (o_rvalid !== 1'b1 || o_rdata !== 32'hB0B0_B0B0) begin
            n_fail++;
            $display("FAIL b2b_resp2 got v=%0b d=%h exp 1 b0b0b0b0", o_rvalid, o_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int pulses0;
        pulses0 = n_pulses;
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_addr = 32'h4000_0300; i_wdata = 32'h0000_0055; i_be = 4'hF; i_priv = 1'b0;
        @(negedge i_clk);
        i_req = 1'b0; #1;
        n_tests++;
        if (axi.awvalid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got %0b exp 1", axi.awvalid); end
        #2;
        i_rst_n = 1'b0; #1;
        n_tests++;
        if ({axi.awvalid, axi.wvalid, axi.bready, o_rvalid, o_gnt} !== 5'b00000) begin
            n_fail++;
            $display("FAIL rst_mid_async got %b exp 00000", {axi.awvalid, axi.wvalid, axi.bready, o_rvalid, o_gnt});
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1; i_req = 1'b1; i_we = 1'b0; #1;
        n_tests++;
        if (o_gnt !== 1'b1 || axi.awvalid !== 1'b0 || axi.arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle got g=%0b aw=%0b ar=%0b exp 1 0 0", o_gnt, axi.awvalid, axi.arvalid);
        end
        #1;
        i_req = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        n_tests++;
        if (n_pulses !== pulses0 || axi.arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_noresp got pulses=%0d ar=%0b exp 0 0", n_pulses - pulses0, axi.arvalid);
        end
    endtask

    initial begin
        test_reset();
        test_write_aw_first();
        test_read();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge i_clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got %0d pending exp 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/k10_peri_axil_master.md
Name: k10_peri_axil_master

Overview:
- Initiator end of the K10 peripheral AXI4-Lite port: converts the core's single-outstanding data-port request (req/gnt, registered response) into AXI4-Lite master transactions.
- Its m_axi_* outputs drive the peripheral address decoder, which routes to the timer and the sim controller.
- Supports independent AW/W acceptance, SLVERR/DECERR reporting, and a bounded response timeout with protocol-safe draining of late responses.

Parameters:
- TIMEOUT_CYCLES, 256: cycles from request accept to response before an error is reported; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  core request valid
- o_gnt  out  1  request accepted this cycle
- i_we  in  1  1 = write, 0 = read
- i_addr  in  32  byte address
- i_wdata  in  32  write data
- i_be  in  4  byte enables
- i_priv  in  1  machine-mode access; drives prot[0]
- o_rvalid  out  1  one-cycle response pulse
- o_rdata  out  32  read data, valid with o_rvalid
- o_err  out  1  error, valid with o_rvalid
- m_axi_awaddr/awprot/awvalid  out  32/3/1; m_axi_awready  in  1
- m_axi_wdata/wstrb/wvalid  out  32/4/1; m_axi_wready  in  1
- m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1
- m_axi_araddr/arprot/arvalid  out  32/3/1; m_axi_arready  in  1
- m_axi_rdata  in  32; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1

Behaviour:
- Reset values: state IDLE; all valids, bready, rready, o_gnt, o_rvalid and o_err = 0; o_rdata and address/data registers = 0; timeout counter = 0.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - o_gnt = i_req (combinational).
  - On grant, register addr, wdata, be and prot = {1'b0, 1'b0, i_priv}; clear aw_done, w_done and timed_out; load counter = 0.
  - Go to WRITE if i_we, else READ.
- WRITE:
  - awvalid = !aw_done; wvalid = !w_done; bready = aw_done && w_done.
  - AW and W handshakes complete in any order or in the same cycle; each sets its done flag.
  - B handshake (bvalid && bready) returns to IDLE. o_rvalid pulses the following cycle with o_err = (bresp != 2'b00) and o_rdata = 0.
- READ:
  - arvalid high until the AR handshake; rready high once AR is done.
  - R handshake returns to IDLE. o_rvalid pulses the following cycle with o_rdata = rdata and o_err = (rresp != 2'b00).
- Valids, once asserted, are never dropped before their handshake, and the address, data, strobe and prot registers stay stable meanwhile. Timeout and error conditions do not override this.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments every cycle in WRITE or READ.
  - When it reaches TIMEOUT_CYCLES, the next cycle pulses o_rvalid with o_err = 1 and o_rdata = 0, and the FSM moves to DRAIN.
- DRAIN:
  - Keep driving any pending AW/W/AR until its handshake, then hold bready/rready high until the response handshake.
  - Discard the response (no o_rvalid), then go to IDLE. o_gnt = 0 throughout.
- A response handshake in the same cycle the counter reaches TIMEOUT_CYCLES counts as a normal completion; no timeout is reported.
- Response latency: o_rvalid rises exactly 1 cycle after the B/R handshake cycle; o_gnt can rise in that same cycle (back-to-back).
- Only one transaction is outstanding at a time; no request is accepted outside IDLE.
- Reset mid-transaction: all outputs return to reset values asynchronously; no response is issued for the aborted request.

Test Plan:
- Write, AW first: grant with addr 0x4000_1000, wdata 0xDEADBEEF, be 0xF; awready at cycle 1, wready at cycle 3, bvalid with OKAY at cycle 5 -> awaddr held stable until cycle 1 and wvalid until cycle 3; o_rvalid = 1, o_err = 0 at cycle 6.
- Read: grant with addr 0x4000_0008; arready immediately, rvalid 2 cycles later with rdata 0x1234_5678 and OKAY -> o_rdata = 0x12345678, o_err = 0, one o_rvalid pulse.
- Error responses: write returning bresp SLVERR (2'b10) -> o_err = 1; read returning rresp DECERR (2'b11) -> o_err = 1, o_rdata = rdata.
- Timeout: TIMEOUT_CYCLES = 8, read with arready but no rvalid -> o_rvalid with o_err = 1 at cycle 9; o_gnt stays 0 while in DRAIN; a late rvalid at cycle 20 is consumed with rready = 1 and produces no o_rvalid; the next request is granted afterwards.
- Back-to-back: i_req held high across two reads -> second o_gnt coincides with the first o_rvalid; AXI handshake legality holds throughout.
- Reset mid-transaction: assert i_rst_n = 0 while awvalid = 1 -> awvalid, wvalid, bready and o_rvalid all 0 immediately; after release, the FSM is in IDLE with o_gnt = i_req.
